// File: rtl/entry_alloc_tracker_pkg.sv
// -----------------------------------------------------------------------------
// entry_alloc_tracker_pkg
// Shared defaults and types for the entry allocation tracker.
//   NUM_ENTRIES_DEF : default number of tracked entries (RS/ROB slots)
//   ALLOC_WIDTH_DEF : default maximum allocations per cycle
//   entry_idx_t     : index of one entry
//   alloc_cnt_t     : allocation request/grant count (0..ALLOC_WIDTH)
//   free_cnt_t      : free-entry count (0..NUM_ENTRIES)
// -----------------------------------------------------------------------------
package entry_alloc_tracker_pkg;

   localparam int unsigned NUM_ENTRIES_DEF = 16;
   localparam int unsigned ALLOC_WIDTH_DEF = 4;

   typedef logic [$clog2(NUM_ENTRIES_DEF)-1:0]   entry_idx_t;
   typedef logic [$clog2(ALLOC_WIDTH_DEF+1)-1:0] alloc_cnt_t;
   typedef logic [$clog2(NUM_ENTRIES_DEF+1)-1:0] free_cnt_t;

endpackage

// File: rtl/entry_alloc_tracker_multi_psel.sv
// -----------------------------------------------------------------------------
// multi_psel
// Picks the N_LANE lowest set bits of a request vector, lowest first.
// Lane k carries the one-hot position of the k-th lowest set bit, or zero
// when fewer than k+1 bits are set.
//   req_i      : request vector (one bit per candidate)
//   grant_oh_o : per-lane one-hot grant, lane 0 holds the lowest set bit
// -----------------------------------------------------------------------------
module multi_psel
   import entry_alloc_tracker_pkg::*;
#(
   parameter int unsigned N_REQ  = NUM_ENTRIES_DEF,
   parameter int unsigned N_LANE = ALLOC_WIDTH_DEF
)(
   input  logic [N_REQ-1:0]             req_i,
   output logic [N_LANE-1:0][N_REQ-1:0] grant_oh_o
);

   logic [N_REQ-1:0] rem_s;
   logic [N_REQ-1:0] low_s;

   // Peel off the lowest remaining set bit once per lane.
   always_comb begin
      rem_s      = req_i;
      low_s      = '0;
      grant_oh_o = '0;
      for (int unsigned l = 0; l < N_LANE; l++) begin
         // two's-complement trick isolates the lowest set bit
         low_s         = rem_s & (~rem_s + N_REQ'(1));
         grant_oh_o[l] = low_s;
         rem_s         = rem_s & ~low_s;
      end
   end

endmodule

// File: rtl/entry_alloc_tracker.sv
// -----------------------------------------------------------------------------
// entry_alloc_tracker
// Tracks busy/free state of NUM_ENTRIES slots and grants up to ALLOC_WIDTH of
// the lowest-indexed free slots per cycle.
//   clock      : sole clock, rising edge
//   reset_n    : asynchronous active-low reset
//   alloc_num  : entries requested this cycle (clamped to ALLOC_WIDTH)
//   free_mask  : one bit per entry released this cycle
//   flush      : release all entries, no grants this cycle
//   grant_num  : entries granted this cycle (combinational)
//   grant_idx  : granted indices, lowest in lane 0, unused lanes 0
//   grant_vld  : thermometer lane valid (lanes 0..grant_num-1)
//   free_count : registered free-entry count, in step with the busy vector
//   full/empty : free_count==0 / free_count==NUM_ENTRIES (registered)
// Optional feature macro: ALLOC_BYPASS_EN -- entries freed this cycle are
// grantable in the same cycle. Without it, free_mask has no combinational
// path to the grant outputs.
// Assumes NUM_ENTRIES >= ALLOC_WIDTH.
// -----------------------------------------------------------------------------
module entry_alloc_tracker
   import entry_alloc_tracker_pkg::*;
#(
   parameter  int unsigned NUM_ENTRIES = NUM_ENTRIES_DEF,
   parameter  int unsigned ALLOC_WIDTH = ALLOC_WIDTH_DEF,
   localparam int unsigned IDX_W       = $clog2(NUM_ENTRIES),
   localparam int unsigned CNT_W       = $clog2(ALLOC_WIDTH+1),
   localparam int unsigned FC_W        = $clog2(NUM_ENTRIES+1)
)(
   input  logic                              clock,
   input  logic                              reset_n,
   input  logic [CNT_W-1:0]                  alloc_num,
   input  logic [NUM_ENTRIES-1:0]            free_mask,
   input  logic                              flush,
   output logic [CNT_W-1:0]                  grant_num,
   output logic [ALLOC_WIDTH-1:0][IDX_W-1:0] grant_idx,
   output logic [ALLOC_WIDTH-1:0]            grant_vld,
   output logic [FC_W-1:0]                   free_count,
   output logic                              full,
   output logic                              empty
);

   // Count of set bits in an entry vector.
   function automatic logic [FC_W-1:0] popcnt(input logic [NUM_ENTRIES-1:0] v);
      logic [FC_W-1:0] c;
      c = '0;
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
         c = c + FC_W'(v[i]);
      end
      return c;
   endfunction

   // Binary index of a one-hot entry vector (zero for an all-zero vector).
   function automatic logic [IDX_W-1:0] oh2idx(input logic [NUM_ENTRIES-1:0] oh);
      logic [IDX_W-1:0] idx;
      idx = '0;
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
         idx = idx | ({IDX_W{oh[i]}} & IDX_W'(i));
      end
      return idx;
   endfunction

   logic [NUM_ENTRIES-1:0]                  busy_q;
   logic [NUM_ENTRIES-1:0]                  busy_d;
   logic [FC_W-1:0]                         free_count_q;
   logic [FC_W-1:0]                         free_count_d;
   logic                                    full_q;
   logic                                    empty_q;
   logic [NUM_ENTRIES-1:0]                  avail_s;
   logic [FC_W-1:0]                         limit_s;
   logic [FC_W-1:0]                         req_s;
   logic [FC_W-1:0]                         gnum_s;
   logic [NUM_ENTRIES-1:0]                  granted_s;
   logic [ALLOC_WIDTH-1:0][NUM_ENTRIES-1:0] lane_oh_s;

`ifdef ALLOC_BYPASS_EN
   // Entries released this cycle are immediately grantable.
   assign avail_s = ~busy_q | free_mask;
   assign limit_s = free_count_q + popcnt(free_mask & busy_q);
`else
   // Only entries already free in the registered state are grantable.
   assign avail_s = ~busy_q;
   assign limit_s = free_count_q;
`endif

   // Grant count: min(clamped request, grantable entries); zero in flush/reset.
   always_comb begin
      if (FC_W'(alloc_num) > FC_W'(ALLOC_WIDTH)) begin
         req_s = FC_W'(ALLOC_WIDTH);
      end else begin
         req_s = FC_W'(alloc_num);
      end
      if (!reset_n || flush) begin
         gnum_s = '0;
      end else if (req_s < limit_s) begin
         gnum_s = req_s;
      end else begin
         gnum_s = limit_s;
      end
      grant_num = CNT_W'(gnum_s);
   end

   multi_psel #(
      .N_REQ  (NUM_ENTRIES),
      .N_LANE (ALLOC_WIDTH)
   ) u_psel (
      .req_i      (avail_s),
      .grant_oh_o (lane_oh_s)
   );

   // Lane outputs: only the first gnum_s lanes are live; the rest drive zero.
   always_comb begin
      grant_idx = '0;
      grant_vld = '0;
      granted_s = '0;
      for (int unsigned l = 0; l < ALLOC_WIDTH; l++) begin
         if (FC_W'(l) < gnum_s) begin
            grant_vld[l] = 1'b1;
            grant_idx[l] = oh2idx(lane_oh_s[l]);
            granted_s    = granted_s | lane_oh_s[l];
         end else begin
            grant_vld[l] = 1'b0;
            grant_idx[l] = '0;
         end
      end
   end

   // Next busy state: release first, then mark grants (a bypassed entry ends busy).
   always_comb begin
      if (flush) begin
         busy_d = '0;
      end else begin
         busy_d = (busy_q & ~free_mask) | granted_s;
      end
      free_count_d = popcnt(~busy_d);
   end

   // State registers; count and flags are loaded from next state so they never lag busy.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         busy_q       <= '0;
         free_count_q <= FC_W'(NUM_ENTRIES);
         full_q       <= 1'b0;
         empty_q      <= 1'b1;
      end else begin
         busy_q       <= busy_d;
         free_count_q <= free_count_d;
         full_q       <= (free_count_d == '0);
         empty_q      <= (free_count_d == FC_W'(NUM_ENTRIES));
      end
   end

   assign free_count = free_count_q;
   assign full       = full_q;
   assign empty      = empty_q;

endmodule

// File: tb/tb_entry_alloc_tracker.sv
// -----------------------------------------------------------------------------
// tb_entry_alloc_tracker
// Scoreboard bench: the driver computes expected grants from a slot-list model
// and queues them; a monitor pops and compares once per cycle.
// -----------------------------------------------------------------------------
module tb_entry_alloc_tracker;

`ifdef ALLOC_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   logic             clock;
   logic             reset_n;
   logic [2:0]       alloc_num;
   logic [15:0]      free_mask;
   logic             flush;
   logic [2:0]       grant_num;
   logic [3:0][3:0]  grant_idx;
   logic [3:0]       grant_vld;
   logic [4:0]       free_count;
   logic             full;
   logic             empty;

   typedef struct {
      int          gnum;
      logic [3:0]  vld;
      logic [15:0] idx;
      int          fc;
      bit          full;
      bit          empty;
   } exp_t;

   exp_t exp_q[$];
   bit   busy_m[16];
   int   checks   = 0;
   int   failures = 0;

   entry_alloc_tracker dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .alloc_num  (alloc_num),
      .free_mask  (free_mask),
      .flush      (flush),
      .grant_num  (grant_num),
      .grant_idx  (grant_idx),
      .grant_vld  (grant_vld),
      .free_count (free_count),
      .full       (full),
      .empty      (empty)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // One cycle of stimulus: drive, predict, queue the prediction, advance model.
   task automatic step(input int an, input logic [15:0] fm, input bit fl);
      exp_t e;
      bit   avail[16];
      int   free_n, limit, req, g, picked;
      @(negedge clock);
      alloc_num = 3'(an);
      free_mask = fm;
      flush     = fl;
      free_n = 0;
      limit  = 0;
      for (int i = 0; i < 16; i++) begin
         if (!busy_m[i]) free_n++;
         avail[i] = !busy_m[i] || (BYPASS && fm[i]);
         if (avail[i]) limit++;
      end
      req    = (an > 4) ? 4 : an;
      g      = fl ? 0 : ((req < limit) ? req : limit);
      e.gnum = g;
      e.vld  = '0;
      e.idx  = '0;
      e.fc   = free_n;
      e.full = (free_n == 0);
      e.empty = (free_n == 16);
      picked = 0;
      for (int i = 0; i < 16; i++) begin
         bit pick;
         pick = avail[i] && (picked < g);
         if (pick) begin
            e.vld[picked]          = 1'b1;
            e.idx[picked*4 +: 4]   = 4'(i);
            picked++;
         end
         busy_m[i] = fl ? 1'b0 : ((busy_m[i] && !fm[i]) || pick);
      end
      exp_q.push_back(e);
   endtask

   // Monitor: compare the queued expectation against outputs mid-cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("grant_num",  int'(grant_num),  e.gnum);
            chk("grant_vld",  int'(grant_vld),  int'(e.vld));
            chk("grant_idx",  int'(grant_idx),  int'(e.idx));
            chk("free_count", int'(free_count), e.fc);
            chk("full",       int'(full),       int'(e.full));
            chk("empty",      int'(empty),      int'(e.empty));
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n   = 1'b0;
      alloc_num = 3'd4;
      free_mask = 16'h0000;
      flush     = 1'b0;
      for (int i = 0; i < 16; i++) busy_m[i] = 1'b0;
      #12;
      chk("rst_free_count", int'(free_count), 16);
      chk("rst_empty",      int'(empty),      1);
      chk("rst_full",       int'(full),       0);
      chk("rst_grant_num",  int'(grant_num),  0);
      chk("rst_grant_vld",  int'(grant_vld),  0);
      chk("rst_grant_idx",  int'(grant_idx),  0);
      @(negedge clock);
      alloc_num = 3'd0;
      reset_n   = 1'b1;

      // fill, then over-request while full
      repeat (4) step(4, 16'h0000, 1'b0);
      step(3, 16'h0000, 1'b0);
      // free entry 0 while full and ask for one
      step(1, 16'h0001, 1'b0);
      step(1, 16'h0000, 1'b0);
      // leave only entries 5 and 9 free
      step(0, 16'h0220, 1'b0);
      step(4, 16'h0000, 1'b0);
      // flush with competing alloc/free
      step(0, 16'h0000, 1'b1);
      step(4, 16'h0000, 1'b0);
      step(4, 16'h0000, 1'b0);
      step(4, 16'h00FF, 1'b1);
      step(0, 16'h0000, 1'b0);

      // randomized traffic, alloc_num up to 7 to exercise clamping
      for (int n = 0; n < 400; n++) begin
         step(int'($urandom_range(0, 7)), 16'($urandom & $urandom),
              ($urandom_range(0, 31) == 0));
      end

      // mid-stream asynchronous reset with 10 busy
      step(0, 16'h0000, 1'b1);
      step(4, 16'h0000, 1'b0);
      step(4, 16'h0000, 1'b0);
      step(2, 16'h0000, 1'b0);
      @(negedge clock);
      alloc_num = 3'd0;
      #3;
      chk("pre_rst_free_count", int'(free_count), 6);
      reset_n   = 1'b0;
      alloc_num = 3'd4;
      #1;
      chk("async_free_count", int'(free_count), 16);
      chk("async_grant_vld",  int'(grant_vld),  0);
      chk("async_grant_num",  int'(grant_num),  0);
      chk("async_grant_idx",  int'(grant_idx),  0);
      chk("async_empty",      int'(empty),      1);
      for (int i = 0; i < 16; i++) busy_m[i] = 1'b0;
      @(negedge clock);
      alloc_num = 3'd0;
      reset_n   = 1'b1;
      step(4, 16'h0000, 1'b0);
      step(0, 16'h0000, 1'b0);
      step(0, 16'h0000, 1'b0);
      @(negedge clock);
      #4;
      chk("scoreboard_drained", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/entry_alloc_tracker.md
ENTRY_ALLOC_TRACKER -- requirements
Module: entry_alloc_tracker

Interface
REQ-001 SHALL have parameter NUM_ENTRIES, default 16: tracked entries (RS/ROB slots).
REQ-002 SHALL have parameter ALLOC_WIDTH, default 4: max allocations per cycle.
REQ-003 SHALL have port clock  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port alloc_num  input  $clog2(ALLOC_WIDTH+1)  entries requested this cycle.
REQ-006 SHALL have port free_mask  input  NUM_ENTRIES  one bit per entry released this cycle.
REQ-007 SHALL have port flush  input  1  release all entries.
REQ-008 SHALL have port grant_num  output  $clog2(ALLOC_WIDTH+1)  entries granted this cycle.
REQ-009 SHALL have port grant_idx  output  ALLOC_WIDTH x $clog2(NUM_ENTRIES)  granted indices, lowest index in lane 0.
REQ-010 SHALL have port grant_vld  output  ALLOC_WIDTH  lane valid, thermometer-coded (lanes 0..grant_num-1).
REQ-011 SHALL have port free_count  output  $clog2(NUM_ENTRIES+1)  registered free-entry count.
REQ-012 SHALL have port full / empty  output  1 each  free_count==0 / free_count==NUM_ENTRIES.

Function
REQ-013 SHALL hold a registered busy vector, one bit per entry.
REQ-014 grant_num SHALL equal min(alloc_num, free_count, ALLOC_WIDTH), combinational from current state.
REQ-015 Granted lanes SHALL select the grant_num lowest-indexed non-busy entries; unused lanes drive index 0, valid 0.
REQ-016 On rising edge, granted entries SHALL become busy; entries with free_mask set SHALL become non-busy.
REQ-017 free_mask on a non-busy entry SHALL be ignored without error.
REQ-018 Without bypass, an entry freed in cycle N SHALL not be grantable before cycle N+1.
REQ-019 flush SHALL dominate: next state all non-busy, grant_num forced 0 in the flush cycle.
REQ-020 free_count SHALL be registered and equal popcount(~busy) of the state it accompanies (zero-lag with busy).
REQ-021 alloc_num > ALLOC_WIDTH SHALL be clamped to ALLOC_WIDTH.
REQ-022 alloc_num=0 SHALL produce grant_num=0 and all grant_vld low.

Reset
REQ-023 reset_n low SHALL asynchronously clear busy, set free_count=NUM_ENTRIES, empty=1, full=0.
REQ-024 During reset, grant_num=0, grant_vld=0, grant_idx=0; reset mid-operation discards all allocations.

Configuration
REQ-025 Macro ALLOC_BYPASS_EN defined: entries freed in cycle N SHALL be grantable in cycle N (free-to-alloc bypass); grant_num limit uses free_count + popcount(free_mask & busy).
REQ-026 Macro undefined: REQ-018 holds; no combinational path from free_mask to grant outputs.

Structure
REQ-027 A shared package SHALL hold NUM_ENTRIES/ALLOC_WIDTH defaults and typedefs entry_idx_t, alloc_cnt_t, free_cnt_t.
REQ-028 One sub-module, multi_psel, SHALL pick the ALLOC_WIDTH lowest set bits of a request vector as one-hot grants; popcounts reuse the existing counter block.

Verification (NUM_ENTRIES=16, ALLOC_WIDTH=4)
REQ-029 Reset release, alloc_num=4 -> grant_idx {0,1,2,3}, grant_num=4; next cycle free_count=12.
REQ-030 Four cycles alloc_num=4 -> full=1, free_count=0; fifth request alloc_num=3 -> grant_num=0.
REQ-031 Busy all except entries 5,9; alloc_num=4 -> grant_num=2, grant_idx {5,9}, vld 4'b0011.
REQ-032 Full, free_mask=16'h0001 with alloc_num=1 -> grant_num=0 without ALLOC_BYPASS_EN, grant_idx0=0 with it; next cycle free_count=1 / 0 respectively.
REQ-033 8 busy, flush=1 with alloc_num=4 and free_mask=16'h00FF -> grant_num=0; next cycle free_count=16, empty=1.
REQ-034 reset_n low mid-stream with 10 busy -> immediately free_count=16, grant_vld=0, independent of clock.
